// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: scoreboards in-flight destinations, stalls ID on
// load-use, and drives registered forward selects plus the EX operand muxes.
module fwd_hazard_unit #(
   parameter  int XLEN     = 32,
   parameter  int NREAD    = 2,
   parameter  int DEPTH    = 2,
   parameter  int LOAD_LAT = 1,
   localparam int SELW     = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid,
   input  logic [NREAD*5-1:0]      id_rs,
   input  logic [NREAD-1:0]        id_rs_used,
   input  logic [4:0]              id_rd,
   input  logic                    id_we,
   input  logic                    id_is_load,
   input  logic                    flush,
   input  logic [NREAD*XLEN-1:0]   ex_rf_data,
   input  logic [DEPTH*XLEN-1:0]   fwd_data,
   output logic                    stall,
   output logic [NREAD*SELW-1:0]   ex_sel,
   output logic [NREAD*XLEN-1:0]   ex_op
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       we;
      logic       is_load;
   } sb_entry_t;

   sb_entry_t                 r_t [1:DEPTH];
   sb_entry_t                 w_t1_next;
   logic [NREAD*DEPTH-1:0]    w_match;
   logic [NREAD*SELW-1:0]     w_sel;
   logic [NREAD*SELW-1:0]     r_ex_sel;
   logic                      w_hazard;
   logic                      w_advance;

   genvar gi, gk;

   // Flat match vector: bit (port*DEPTH + stage-1).
   generate
      for (gi = 0; gi < NREAD; gi++) begin : g_port_match
         for (gk = 1; gk <= DEPTH; gk++) begin : g_stage_match
            assign w_match[gi*DEPTH + gk - 1] = r_t[gk].valid & r_t[gk].we
                                              & (r_t[gk].rd == id_rs[5*gi +: 5])
                                              & (id_rs[5*gi +: 5] != 5'd0)
                                              & id_rs_used[gi];
         end
      end
   endgenerate

   // Scanning from the far end lets the nearest producer overwrite the select last.
   always_comb begin
      w_sel    = '0;
      w_hazard = 1'b0;
      for (int p = 0; p < NREAD; p++) begin
         for (int k = DEPTH; k >= 1; k--) begin
            if (w_match[p*DEPTH + k - 1]) begin
               w_sel[p*SELW +: SELW] = SELW'(k);
               if (r_t[k].is_load && (k <= LOAD_LAT)) begin
                  w_hazard = 1'b1;
               end
            end
         end
      end
   end

   assign stall     = id_valid & w_hazard & ~flush & ~rst;
   assign w_advance = id_valid & ~w_hazard & ~flush;

   always_comb begin
      w_t1_next = '0;
      if (w_advance) begin
         w_t1_next.valid   = 1'b1;
         w_t1_next.rd      = id_rd;
         w_t1_next.we      = id_we;
         w_t1_next.is_load = id_is_load;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_t[1]   <= '0;
         r_ex_sel <= '0;
      end else begin
         r_t[1]   <= w_t1_next;
         r_ex_sel <= w_advance ? w_sel : '0;
      end
   end

   generate
      for (gk = 2; gk <= DEPTH; gk++) begin : g_shift
         always_ff @(posedge clk) begin
            if (rst) begin
               r_t[gk] <= '0;
            end else begin
               r_t[gk] <= r_t[gk-1];
            end
         end
      end
   endgenerate

   assign ex_sel = r_ex_sel;

   // Out-of-range selects fall through to the register-file operand.
   generate
      for (gi = 0; gi < NREAD; gi++) begin : g_op_mux
         logic [XLEN-1:0] w_op;
         always_comb begin
            w_op = ex_rf_data[gi*XLEN +: XLEN];
            if (!rst) begin
               for (int k = 1; k <= DEPTH; k++) begin
                  if (r_ex_sel[gi*SELW +: SELW] == SELW'(k)) begin
                     w_op = fwd_data[(k-1)*XLEN +: XLEN];
                  end
               end
            end
         end
         assign ex_op[gi*XLEN +: XLEN] = w_op;
      end
   endgenerate

endmodule
